// File: rtl/vga_timing_pkg.sv
// Shared VGA raster timing: default 640x480@60 constants and helpers that
// derive line/frame totals and sync pulse positions from porch widths.
package vga_timing_pkg;

    localparam int COORD_W   = 10;
    localparam int MAX_TOTAL = 1 << COORD_W;

    localparam int DEF_CLK_DIV   = 2;
    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    function automatic int line_total(input int disp, input int front,
                                      input int sync, input int back);
        return disp + front + sync + back;
    endfunction

    function automatic int sync_start(input int disp, input int front);
        return disp + front;
    endfunction

    function automatic int sync_end(input int disp, input int front, input int sync);
        return disp + front + sync - 1;
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Mod-CLK_DIV counter producing a one-clock pixel-rate enable; with
// CLK_DIV = 1 the enable is permanently high.
module pixel_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic p_tick_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("pixel_tick_gen: CLK_DIV must be >= 1");
    end

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;

    assign p_tick_o = (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d = p_tick_o ? '0 : div_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel/line counters advanced by a pixel-rate
// enable, with every output decoded from the next-state counts so they align.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               p_tick,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_start
);

    localparam int H_TOTAL = line_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = line_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_timing
        $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_DISP_C = COORD_W'(H_DISPLAY);
    localparam logic [COORD_W-1:0] V_DISP_C = COORD_W'(V_DISPLAY);
    localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(sync_start(H_DISPLAY, H_FRONT));
    localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(sync_end(H_DISPLAY, H_FRONT, H_SYNC));
    localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(sync_start(V_DISPLAY, V_FRONT));
    localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(sync_end(V_DISPLAY, V_FRONT, V_SYNC));

    logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
    logic [COORD_W-1:0] v_cnt_q, v_cnt_d;
    logic               video_on_q, video_on_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               frame_start_q, frame_start_d;
    logic               h_last, v_last;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_i    (clk),
        .rst_ni   (reset_n),
        .p_tick_o (p_tick)
    );

    assign h_last = (h_cnt_q == H_LAST);
    assign v_last = (v_cnt_q == V_LAST);

    // Decoding the next-state counts keeps sync/video flags aligned with pixel_x/y.
    always_comb begin
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        frame_start_d = 1'b0;
        if (p_tick) begin
            if (h_last) begin
                h_cnt_d       = '0;
                v_cnt_d       = v_last ? '0 : v_cnt_q + 1'b1;
                frame_start_d = v_last;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
        video_on_d = (h_cnt_d < H_DISP_C) && (v_cnt_d < V_DISP_C);
        hsync_d    = (h_cnt_d >= HS_FIRST && h_cnt_d <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
        vsync_d    = (v_cnt_d >= VS_FIRST && v_cnt_d <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            video_on_q    <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            video_on_q    <= video_on_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pixel_x     = h_cnt_q;
    assign pixel_y     = v_cnt_q;
    assign video_on    = video_on_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: a default 640x480 instance (CLK_DIV=2) and
// a tiny-raster instance (CLK_DIV=1, active-high sync) so whole frames fit.
module tb_vga_sync_gen;

    typedef struct {
        int         k;
        logic [9:0] x;
        logic [9:0] y;
        logic       von;
        logic       hs;
        logic       vs;
        logic       fs;
        logic       pt;
    } exp_t;

    logic       clk;
    logic       reset_n;
    int         cyc;
    int         checks;
    int         errors;
    int         fsCountA, fsCountB, vonTicksA, hsLowA;
    exp_t       qA[$];
    exp_t       qB[$];

    logic       ptA, vonA, hsA, vsA, fsA;
    logic [9:0] xA, yA;
    logic       ptB, vonB, hsB, vsB, fsB;
    logic [9:0] xB, yB;

    vga_sync_gen dutA (
        .clk         (clk),
        .reset_n     (reset_n),
        .p_tick      (ptA),
        .pixel_x     (xA),
        .pixel_y     (yA),
        .video_on    (vonA),
        .hsync       (hsA),
        .vsync       (vsA),
        .frame_start (fsA)
    );

    // 15 x 8 raster: hsync at x 10..12, vsync at y 5..6, active-high.
    vga_sync_gen #(
        .CLK_DIV   (1),
        .H_DISPLAY (8),
        .H_FRONT   (2),
        .H_SYNC    (3),
        .H_BACK    (2),
        .V_DISPLAY (4),
        .V_FRONT   (1),
        .V_SYNC    (2),
        .V_BACK    (1),
        .SYNC_POL  (1'b1)
    ) dutB (
        .clk         (clk),
        .reset_n     (reset_n),
        .p_tick      (ptB),
        .pixel_x     (xB),
        .pixel_y     (yB),
        .video_on    (vonB),
        .hsync       (hsB),
        .vsync       (vsB),
        .frame_start (fsB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    function automatic exp_t mk(input int k, input int x, input int y, input bit von,
                                input bit hs, input bit vs, input bit fs, input bit pt);
        exp_t e;
        e.k = k; e.x = 10'(x); e.y = 10'(y);
        e.von = von; e.hs = hs; e.vs = vs; e.fs = fs; e.pt = pt;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input exp_t e, input logic [9:0] x,
                               input logic [9:0] y, input logic von, input logic hs,
                               input logic vs, input logic fs, input logic pt);
        logic [24:0] act, req;
        act = {x, y, von, hs, vs, fs, pt};
        req = {e.x, e.y, e.von, e.hs, e.vs, e.fs, e.pt};
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s k=%0d: got x=%0d y=%0d von=%b hs=%b vs=%b fs=%b pt=%b, expected x=%0d y=%0d von=%b hs=%b vs=%b fs=%b pt=%b",
                     tag, e.k, x, y, von, hs, vs, fs, pt, e.x, e.y, e.von, e.hs, e.vs, e.fs, e.pt);
        end
    endtask

    task automatic checkCount(input string tag, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, req);
        end
    endtask

    task automatic applyStimulus(input logic rstVal);
        @(negedge clk);
        #1 reset_n = rstVal;
    endtask

    task automatic waitCycle(input int target);
        for (int i = 0; i < 5000 && cyc != target; i++) @(negedge clk);
        checkCount("cycle wait", cyc, target);
    endtask

    // Monitor: pop expectations whose cycle tag matches and tally line/frame events.
    always @(negedge clk) begin
        if (reset_n) begin
            while (qA.size() > 0 && qA[0].k <= cyc) begin
                exp_t e;
                e = qA.pop_front();
                if (e.k < cyc) checkCount("A missed sample", cyc, e.k);
                else checkOutput("A", e, xA, yA, vonA, hsA, vsA, fsA, ptA);
            end
            while (qB.size() > 0 && qB[0].k <= cyc) begin
                exp_t e;
                e = qB.pop_front();
                if (e.k < cyc) checkCount("B missed sample", cyc, e.k);
                else checkOutput("B", e, xB, yB, vonB, hsB, vsB, fsB, ptB);
            end
            if (yA == 10'd0 && vonA && ptA) vonTicksA++;
            if (yA == 10'd0 && !hsA) hsLowA++;
            if (fsA) fsCountA++;
            if (fsB) begin
                fsCountB++;
                checkCount("B frame_start off origin", int'(xB) + int'(yB), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        checks = 0; errors = 0;
        fsCountA = 0; fsCountB = 0; vonTicksA = 0; hsLowA = 0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("A in reset", mk(0, 0, 0, 0, 1, 1, 0, 0), xA, yA, vonA, hsA, vsA, fsA, ptA);
        checkOutput("B in reset", mk(0, 0, 0, 0, 0, 0, 0, 1), xB, yB, vonB, hsB, vsB, fsB, ptB);

        // Default raster: pixel n = k/2 after k edges, p_tick on odd k.
        qA.push_back(mk(1,    0,   0, 1, 1, 1, 0, 1));
        qA.push_back(mk(2,    1,   0, 1, 1, 1, 0, 0));
        qA.push_back(mk(4,    2,   0, 1, 1, 1, 0, 0));
        qA.push_back(mk(1279, 639, 0, 1, 1, 1, 0, 1));
        qA.push_back(mk(1281, 640, 0, 0, 1, 1, 0, 1));
        qA.push_back(mk(1310, 655, 0, 0, 1, 1, 0, 0));
        qA.push_back(mk(1312, 656, 0, 0, 0, 1, 0, 0));
        qA.push_back(mk(1313, 656, 0, 0, 0, 1, 0, 1));
        qA.push_back(mk(1503, 751, 0, 0, 0, 1, 0, 1));
        qA.push_back(mk(1504, 752, 0, 0, 1, 1, 0, 0));
        qA.push_back(mk(1599, 799, 0, 0, 1, 1, 0, 1));
        qA.push_back(mk(1600, 0,   1, 1, 1, 1, 0, 0));
        qA.push_back(mk(3000, 700, 1, 0, 0, 1, 0, 0));

        // Tiny raster: pixel n = k, x = n%15, y = (n/15)%8.
        qB.push_back(mk(1,   1,  0, 1, 0, 0, 0, 1));
        qB.push_back(mk(7,   7,  0, 1, 0, 0, 0, 1));
        qB.push_back(mk(8,   8,  0, 0, 0, 0, 0, 1));
        qB.push_back(mk(9,   9,  0, 0, 0, 0, 0, 1));
        qB.push_back(mk(10,  10, 0, 0, 1, 0, 0, 1));
        qB.push_back(mk(12,  12, 0, 0, 1, 0, 0, 1));
        qB.push_back(mk(13,  13, 0, 0, 0, 0, 0, 1));
        qB.push_back(mk(15,  0,  1, 1, 0, 0, 0, 1));
        qB.push_back(mk(74,  14, 4, 0, 0, 0, 0, 1));
        qB.push_back(mk(75,  0,  5, 0, 0, 1, 0, 1));
        qB.push_back(mk(104, 14, 6, 0, 0, 1, 0, 1));
        qB.push_back(mk(105, 0,  7, 0, 0, 0, 0, 1));
        qB.push_back(mk(119, 14, 7, 0, 0, 0, 0, 1));
        qB.push_back(mk(120, 0,  0, 1, 0, 0, 1, 1));
        qB.push_back(mk(121, 1,  0, 1, 0, 0, 0, 1));
        qB.push_back(mk(240, 0,  0, 1, 0, 0, 1, 1));

        applyStimulus(1'b1);
        waitCycle(3000);
        #2;
        checkCount("A queue drained", qA.size(), 0);
        checkCount("B queue drained", qB.size(), 0);
        checkCount("A video_on ticks line 0", vonTicksA, 640);
        checkCount("A hsync low clks line 0", hsLowA, 192);
        checkCount("A frame_start pulses", fsCountA, 0);
        checkCount("B frame_start pulses", fsCountB, 25);

        // Mid-line reset while dutA is inside its hsync pulse.
        reset_n = 1'b0;
        #1;
        checkOutput("A async reset", mk(3000, 0, 0, 0, 1, 1, 0, 0), xA, yA, vonA, hsA, vsA, fsA, ptA);
        checkOutput("B async reset", mk(3000, 0, 0, 0, 0, 0, 0, 1), xB, yB, vonB, hsB, vsB, fsB, ptB);
        repeat (2) @(negedge clk);

        qA.push_back(mk(1, 0, 0, 1, 1, 1, 0, 1));
        qA.push_back(mk(2, 1, 0, 1, 1, 1, 0, 0));
        qA.push_back(mk(4, 2, 0, 1, 1, 1, 0, 0));
        qB.push_back(mk(1, 1, 0, 1, 0, 0, 0, 1));
        qB.push_back(mk(2, 2, 0, 1, 0, 0, 0, 1));
        applyStimulus(1'b1);
        waitCycle(10);
        #2;
        checkCount("A queue drained after reset", qA.size(), 0);
        checkCount("B queue drained after reset", qB.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Produces the VGA raster timing that the text/font generators consume: pixel coordinates, the active-video flag, and the horizontal/vertical sync pulses for a 640x480 display.
- Derives a pixel-rate enable from the system clock. It runs no separate clock domain.
- Sits between the board clock/reset and every pixel-painting block. Its pixel_x, pixel_y and video_on outputs drive those blocks directly.

Parameters:
- CLK_DIV, 2, system clocks per pixel (2 gives 25 MHz from 50 MHz); legal range >= 1.
- H_DISPLAY, 640, active pixels per line.
- H_FRONT, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync pulse width in pixels.
- H_BACK, 48, horizontal back porch in pixels.
- V_DISPLAY, 480, active lines per frame.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, vsync pulse width in lines.
- V_BACK, 33, vertical back porch in lines.
- SYNC_POL, 0, active level of hsync/vsync (0 means active-low).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- p_tick  out  1  one-clk pulse once per pixel period.
- pixel_x  out  10  current horizontal count, 0..H_TOTAL-1.
- pixel_y  out  10  current vertical count, 0..V_TOTAL-1.
- video_on  out  1  high when pixel_x < H_DISPLAY and pixel_y < V_DISPLAY.
- hsync  out  1  horizontal sync.
- vsync  out  1  vertical sync.
- frame_start  out  1  one-clk pulse when the counters wrap to (0,0).

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, reset_n.
- Derived constants:
  - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800).
  - V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
  - Both totals must be <= 1024; violating this is an elaboration error.
- Divider: div_cnt runs 0..CLK_DIV-1 and wraps. p_tick = 1 when div_cnt == CLK_DIV-1. With CLK_DIV = 1, p_tick is held high.
- Horizontal counter: on a clk edge with p_tick = 1, h_cnt increments. At H_TOTAL-1 it wraps to 0.
- Vertical counter: on the same edge where h_cnt wraps, v_cnt increments. At V_TOTAL-1 it wraps to 0.
- Registered outputs: every output except p_tick is registered and decoded from the next-state counts on the same edge that updates the counters. pixel_x, pixel_y, video_on, hsync and vsync are therefore always mutually aligned, with zero skew.
- hsync is at SYNC_POL when pixel_x is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] (656..751); otherwise it is at ~SYNC_POL.
- vsync is at SYNC_POL when pixel_y is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] (490..491); otherwise it is at ~SYNC_POL.
- frame_start:
  - High for exactly one clk, on the edge where the counts move from (H_TOTAL-1, V_TOTAL-1) to (0,0).
  - Not asserted on the first edge after reset.
- Reset values while reset_n = 0:
  - div_cnt = 0, h_cnt = 0, v_cnt = 0.
  - pixel_x = 0, pixel_y = 0.
  - video_on = 0, frame_start = 0.
  - hsync = vsync = ~SYNC_POL (inactive).
- After reset release:
  - The first clk edge registers the decode of (0,0), so video_on becomes 1.
  - The first p_tick occurs CLK_DIV edges after release.
- Reset mid-frame: the block returns immediately (asynchronously) to the reset values. No partial sync pulse is stretched. Sync goes inactive at once.
- Counter hold: between p_ticks, pixel_x and pixel_y hold their values for exactly CLK_DIV clks.

Decomposition:
- Package vga_timing_pkg holds:
  - the default timing constants for 640x480@60;
  - functions computing H_TOTAL and V_TOTAL and the sync start/end positions;
  - the coordinate width constant (10).
- Sub-module pixel_tick_gen: a mod-CLK_DIV counter with async active-low reset and p_tick output. It is reused later by other pixel-rate blocks.
- The counters and the decode stay in vga_sync_gen.

Test Plan:
- Reset release with CLK_DIV=2 -> first p_tick 2 clks after release; (pixel_x, pixel_y) = (1,0) after 2 clks; (2,0) after 4 clks.
- Run one full line -> pixel_x reaches 799 then 0 after 800 p_ticks (1600 clks); pixel_y steps 0 -> 1 on that edge; video_on high for exactly 640 p_ticks of the line.
- hsync check -> low exactly while pixel_x is 656..751 (96 pixels, 192 clks); high at 655 and 752.
- Full frame -> vsync low only for pixel_y 490..491 (1600 p_ticks); frame_start pulses once per 420000 p_ticks, one clk wide, coincident with (0,0).
- Assert reset_n low at pixel (300,200) mid-clock -> outputs immediately 0 / 0 / video_on=0 / hsync=vsync=1; after release, counting resumes from (0,0).
- CLK_DIV=1 build -> p_tick constantly 1; pixel_x advances every clk; line period 800 clks.
